// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared constants, state encoding and byte-wide CRC-16/CCITT helper for the UART framer pair
package uart_frame_pkg;

    localparam logic [31:0] UF_MAGIC    = 32'hDABBAD00;
    localparam logic [15:0] UF_CRC_POLY = 16'h1021;
    localparam logic [15:0] UF_CRC_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        PAYLOAD = 3'd1,
        CRC_HI  = 3'd2,
        CRC_LO  = 3'd3,
        CHECK   = 3'd4
    } state_e;

    // MSB-first, non-reflected CRC over one byte, fully unrolled
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) c = c[15] ? {c[14:0], 1'b0} ^ UF_CRC_POLY : {c[14:0], 1'b0};
        return c;
    endfunction

endpackage

// File: rtl/crc16_ccitt_byte.sv
// crc16_ccitt_byte: combinational one-byte CRC-16/CCITT update, shared with the frame encoder
module crc16_ccitt_byte
    import uart_frame_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    // whole byte folded in one cycle so back-to-back strobes keep up
    always_comb crc_out = crc16_byte(crc_in, data);

endmodule

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: hunts MAGIC in the uart_rx byte stream, collects payload + CRC-16, publishes good frames.
// Optional inter-byte idle timeout is enabled by defining FRAME_TIMEOUT_EN.
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter int          PAYLOAD_BYTES  = 16,
    parameter logic [31:0] MAGIC          = UF_MAGIC,
    parameter logic [15:0] CRC_INIT       = UF_CRC_INIT,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd2000
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       rx_data_ready,
    input  logic [7:0]                 rx_data,
    output logic [PAYLOAD_BYTES*8-1:0] payload,
    output logic                       frame_valid,
    output logic                       crc_error,
    output logic                       timeout,
    output logic                       busy,
    output logic [15:0]                frame_count,
    output logic [7:0]                 error_count
);

    state_e                     state_q, state_d;
    logic [23:0]                window_q;
    logic [7:0]                 idx_q;
    logic [15:0]                crc_q, crc_next, rx_crc_q;
    logic [PAYLOAD_BYTES*8-1:0] shadow_q, payload_q;
    logic                       frame_valid_q, crc_error_q, timeout_q;
    logic [15:0]                frame_count_q;
    logic [7:0]                 error_count_q;
    logic                       hunting, hit, take, last_byte, good, bad, expire;
    logic [31:0]                shifted;

    // CHECK also shifts a strobe into the header window, starting from a cleared window
    assign hunting   = state_q == HUNT || state_q == CHECK;
    assign shifted   = {(state_q == CHECK ? 24'h0 : window_q), rx_data};
    assign hit       = hunting && rx_data_ready && shifted == MAGIC;
    assign take      = rx_data_ready && state_q == PAYLOAD;
    assign last_byte = idx_q == 8'(PAYLOAD_BYTES - 1);

    crc16_ccitt_byte u_crc (
        .crc_in  (crc_q),
        .data    (rx_data),
        .crc_out (crc_next)
    );

`ifdef FRAME_TIMEOUT_EN
    logic [15:0] idle_q;
    logic        in_frame;
    assign in_frame = state_q inside {PAYLOAD, CRC_HI, CRC_LO};
    assign expire   = in_frame && !rx_data_ready && idle_q == TIMEOUT_CYCLES - 16'd1;
    // idle cycles inside a frame; a strobe or leaving the frame clears it
    always_ff @(posedge CLK) begin
        if (reset || !in_frame || rx_data_ready) idle_q <= '0;
        else idle_q <= idle_q + 16'd1;
    end
`else
    assign expire = 1'b0;
`endif

    // state register
    always_ff @(posedge CLK) begin
        if (reset) state_q <= HUNT;
        else state_q <= state_d;
    end

    // frame sequencing: header, payload bytes, two CRC bytes, one check cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT:    if (hit) state_d = PAYLOAD;
            PAYLOAD: if (rx_data_ready && last_byte) state_d = CRC_HI;
            CRC_HI:  if (rx_data_ready) state_d = CRC_LO;
            CRC_LO:  if (rx_data_ready) state_d = CHECK;
            CHECK:   state_d = hit ? PAYLOAD : HUNT;
            default: state_d = HUNT;
        endcase
        if (expire) state_d = HUNT;
    end

    // status and frame verdict derived from the current state
    always_comb begin
        busy = state_q != HUNT;
        good = state_q == CHECK && rx_crc_q == crc_q;
        bad  = state_q == CHECK && rx_crc_q != crc_q;
    end

    // datapath: header window, shadow buffer, CRC, published payload and counters
    always_ff @(posedge CLK) begin
        if (reset) begin
            window_q      <= '0;
            idx_q         <= '0;
            crc_q         <= CRC_INIT;
            rx_crc_q      <= '0;
            shadow_q      <= '0;
            payload_q     <= '0;
            frame_valid_q <= 1'b0;
            crc_error_q   <= 1'b0;
            timeout_q     <= 1'b0;
            frame_count_q <= '0;
            error_count_q <= '0;
        end else begin
            frame_valid_q <= good;
            crc_error_q   <= bad;
            timeout_q     <= expire;
            if (hunting && rx_data_ready) window_q <= shifted[23:0];
            else if (state_q == CHECK || expire) window_q <= '0;
            if (hit) begin
                idx_q <= '0;
                crc_q <= CRC_INIT;
            end
            if (take) begin
                shadow_q[8*idx_q +: 8] <= rx_data;
                crc_q                  <= crc_next;
                idx_q                  <= idx_q + 8'd1;
            end
            if (rx_data_ready && state_q == CRC_HI) rx_crc_q[15:8] <= rx_data;
            if (rx_data_ready && state_q == CRC_LO) rx_crc_q[7:0] <= rx_data;
            if (good) begin
                payload_q     <= shadow_q;
                frame_count_q <= frame_count_q + 16'd1;
            end
            if ((bad || expire) && error_count_q != 8'hFF) error_count_q <= error_count_q + 8'd1;
        end
    end

    assign payload     = payload_q;
    assign frame_valid = frame_valid_q;
    assign crc_error   = crc_error_q;
    assign timeout     = timeout_q;
    assign frame_count = frame_count_q;
    assign error_count = error_count_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb_uart_frame_decoder: directed frames checked against a byte-stream model every cycle plus literal pins
module tb_uart_frame_decoder;

    localparam int          PB    = 9;
    localparam logic [31:0] MAGIC = 32'hDABBAD00;
    localparam logic [15:0] TO    = 16'd100;
    localparam logic [8*PB-1:0] P1 = 72'h393837363534333231;
    localparam logic [8*PB-1:0] P4 = 72'h554433221100ADBBDA;
`ifdef FRAME_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            CLK = 1'b0, reset = 1'b1, rx_data_ready = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic [8*PB-1:0] payload;
    logic            frame_valid, crc_error, timeout, busy;
    logic [15:0]     frame_count;
    logic [7:0]      error_count;
    int              checks = 0, failures = 0;

    uart_frame_decoder #(
        .PAYLOAD_BYTES  (PB),
        .MAGIC          (MAGIC),
        .CRC_INIT       (16'hFFFF),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .rx_data_ready (rx_data_ready),
        .rx_data       (rx_data),
        .payload       (payload),
        .frame_valid   (frame_valid),
        .crc_error     (crc_error),
        .timeout       (timeout),
        .busy          (busy),
        .frame_count   (frame_count),
        .error_count   (error_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // bit-serial reference CRC over the payload bytes
    function automatic logic [15:0] ref_crc(input logic [8*PB-1:0] pl);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int j = 0; j < PB; j++)
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ pl[8*j+b];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        return c;
    endfunction

    // model: bytes since the last frame boundary; a frame is header + PB bytes + 2 CRC bytes
    logic [7:0]      seg[$];
    int              hdr = -1, idle = 0;
    bit              mvalid = 0, pend = 0, pend_good = 0;
    logic [8*PB-1:0] pend_pl, exp_payload;
    logic            exp_fv, exp_ce, exp_to, exp_busy;
    logic [15:0]     exp_fc;
    logic [7:0]      exp_ec;

    task automatic advance(input logic r, input logic s, input logic [7:0] d);
        int n;
        if (r) begin
            exp_fv = 0; exp_ce = 0; exp_to = 0; exp_busy = 0;
            exp_payload = '0; exp_fc = 0; exp_ec = 0;
            seg.delete(); hdr = -1; pend = 0; idle = 0; mvalid = 1;
            return;
        end
        exp_fv = 0; exp_ce = 0; exp_to = 0;
        if (pend) begin
            pend = 0;
            if (pend_good) begin
                exp_payload = pend_pl; exp_fv = 1; exp_fc = exp_fc + 16'd1;
            end else begin
                exp_ce = 1;
                if (exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
            end
        end
        if (s) begin
            seg.push_back(d);
            n = seg.size();
            idle = 0;
            if (hdr < 0) begin
                if (n >= 4 && {seg[n-4], seg[n-3], seg[n-2], seg[n-1]} == MAGIC) hdr = n;
            end else if (n == hdr + PB + 2) begin
                for (int j = 0; j < PB; j++) pend_pl[8*j +: 8] = seg[hdr+j];
                pend_good = ref_crc(pend_pl) == {seg[hdr+PB], seg[hdr+PB+1]};
                pend = 1; seg.delete(); hdr = -1;
            end
        end else if (TO_EN && hdr >= 0) begin
            idle++;
            if (idle == int'(TO)) begin
                exp_to = 1;
                if (exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
                seg.delete(); hdr = -1;
            end
        end
        exp_busy = hdr >= 0 || pend;
    endtask

    // compare on the falling edge, then step the model with the inputs the next rising edge samples
    initial forever begin
        @(negedge CLK);
        if (mvalid) begin
            check("frame_valid", frame_valid, exp_fv);
            check("crc_error", crc_error, exp_ce);
            check("timeout", timeout, exp_to);
            check("busy", busy, exp_busy);
            check("payload", payload, exp_payload);
            check("frame_count", frame_count, exp_fc);
            check("error_count", error_count, exp_ec);
        end
        advance(reset, rx_data_ready, rx_data);
    end

    logic [7:0] tx[$];

    task automatic push_frame(input logic [8*PB-1:0] pl, input logic [15:0] crc);
        tx.push_back(MAGIC[31:24]); tx.push_back(MAGIC[23:16]);
        tx.push_back(MAGIC[15:8]);  tx.push_back(MAGIC[7:0]);
        for (int j = 0; j < PB; j++) tx.push_back(pl[8*j +: 8]);
        tx.push_back(crc[15:8]); tx.push_back(crc[7:0]);
    endtask

    task automatic send_tx(input int gap);
        for (int i = 0; i < tx.size(); i++) begin
            rx_data_ready = 1'b1; rx_data = tx[i];
            @(posedge CLK); #1;
            rx_data_ready = 1'b0;
            if (i != tx.size() - 1) repeat (gap) begin @(posedge CLK); #1; end
        end
        tx.delete();
    endtask

    task automatic step();
        @(posedge CLK); #1;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1 reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_payload", payload, 0);
        check("rst_fc", frame_count, 0);
        check("rst_ec", error_count, 0);
        // spaced good frame; frame_valid two cycles after last CRC strobe
        push_frame(P1, 16'h29B1); send_tx(2);
        check("t1_fv_check_cycle", frame_valid, 0);
        step();
        check("t1_fv", frame_valid, 1);
        check("t1_pl_lo", payload[7:0], 8'h31);
        check("t1_pl_hi", payload[71:64], 8'h39);
        check("t1_fc", frame_count, 1);
        // bad CRC
        push_frame(P1, 16'h29B0); send_tx(1);
        step();
        check("t2_ce", crc_error, 1);
        check("t2_fv", frame_valid, 0);
        check("t2_pl", payload, P1);
        check("t2_ec", error_count, 1);
        check("t2_fc", frame_count, 1);
        // leading garbage with overlapping header
        tx.push_back(8'h00); tx.push_back(8'hDA);
        push_frame(P1, 16'h29B1); send_tx(1);
        repeat (2) step();
        check("t3_fc", frame_count, 2);
        // back-to-back frames; second header starts in the check cycle; payload carries magic bytes
        push_frame(P1, 16'h29B1);
        push_frame(P4, ref_crc(P4)); send_tx(0);
        step();
        check("t4_fv", frame_valid, 1);
        check("t4_fc", frame_count, 4);
        check("t4_pl", payload, 72'h554433221100ADBBDA);
        // reset mid-frame
        push_frame(P1, 16'h29B1);
        for (int i = 0; i < 4; i++) void'(tx.pop_back());
        send_tx(1);
        reset = 1'b1;
        step();
        check("t5_busy", busy, 0);
        check("t5_pl", payload, 0);
        check("t5_fc", frame_count, 0);
        check("t5_ec", error_count, 0);
        reset = 1'b0;
        push_frame(P1, 16'h29B1); send_tx(3);
        step();
        check("t5_fv", frame_valid, 1);
        check("t5_fc2", frame_count, 1);
        // stalled frame: header + 3 bytes then idle
        push_frame(P1, 16'h29B1);
        for (int i = 0; i < 8; i++) void'(tx.pop_back());
        send_tx(0);
        repeat (110) step();
`ifdef FRAME_TIMEOUT_EN
        check("t6_busy", busy, 0);
        check("t6_ec", error_count, 1);
`else
        check("t6_busy", busy, 1);
        check("t6_to", timeout, 0);
        reset = 1'b1; step(); reset = 1'b0;
`endif
        push_frame(P1, 16'h29B1); send_tx(0);
        step();
        check("t6_fv", frame_valid, 1);
        check("t6_fc", frame_count, TO_EN ? 2 : 1);
        // error counter saturation
        for (int k = 0; k < 260; k++) push_frame(P1, 16'h29B0);
        send_tx(0);
        repeat (2) step();
        check("t7_ec_sat", error_count, 8'hFF);
        check("t7_fc", frame_count, TO_EN ? 2 : 1);
        check("t7_pl", payload, P1);
        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_decoder.md
Name: uart_frame_decoder

Overview:
- Sits directly downstream of uart_rx. Consumes its byte strobe and data, and hunts for the 32-bit magic header 0xDABBAD00.
- Collects a fixed-length payload plus a 2-byte CRC-16/CCITT and checks the CRC. Publishes the payload as a flat bus with a one-cycle valid strobe.
- Replaces the ad-hoc shift-register and magic compare in the top level. Feeds the command/response logic.

Parameters:
- PAYLOAD_BYTES, 16, number of payload bytes between header and CRC (1..255).
- MAGIC, 32'hDABBAD00, header value; first received byte is MAGIC[31:24].
- CRC_INIT, 16'hFFFF, CRC register preset at the start of each payload.
- TIMEOUT_CYCLES, 16'd2000, maximum idle cycles between bytes inside a frame (used only with FRAME_TIMEOUT_EN).

Ports:
- CLK  in  1  system clock (16 MHz).
- reset  in  1  synchronous, active-high reset.
- rx_data_ready  in  1  one-cycle strobe from uart_rx; pulses may be back-to-back.
- rx_data  in  8  byte from uart_rx; valid when rx_data_ready=1.
- payload  out  PAYLOAD_BYTES*8  last good payload; byte j occupies [8j+7:8j].
- frame_valid  out  1  one-cycle pulse: payload just updated with a CRC-good frame.
- crc_error  out  1  one-cycle pulse: frame received, CRC mismatch.
- timeout  out  1  one-cycle pulse: frame aborted on inter-byte timeout.
- busy  out  1  high in any state other than HUNT.
- frame_count  out  16  good frames received; wraps at 0xFFFF->0.
- error_count  out  8  CRC errors plus timeouts; saturates at 0xFF.

Behaviour:
- Reset values (apply on any cycle reset=1, including mid-frame):
  - state=HUNT; header window=0; payload=0.
  - all pulses, busy, frame_count and error_count = 0.
  - In-flight frame is discarded.
- HUNT:
  - On each strobe, window <= {window[23:0], rx_data}.
  - If {window[23:0], rx_data}==MAGIC: go to PAYLOAD, byte index=0, crc=CRC_INIT.
  - Overlapping headers are detected, e.g. DA DA BB AD 00.
- PAYLOAD:
  - On each strobe: store byte in shadow buffer[index], update crc, index++.
  - After byte PAYLOAD_BYTES-1, go to CRC_HI.
  - Magic bytes inside the payload have no effect.
- CRC_HI: strobe latches received CRC[15:8], go to CRC_LO.
- CRC_LO: strobe latches CRC[7:0], go to CHECK.
- CHECK (one cycle, no byte consumed):
  - If received CRC == computed crc: payload <= shadow; frame_valid=1 on the following cycle; frame_count++.
  - Otherwise: crc_error=1; error_count++ (saturating).
  - Always return to HUNT with window=0.
- A strobe arriving in the CHECK cycle is processed by HUNT logic as a window shift. The window is cleared first, then shifted, so no byte is lost.
- CRC definition:
  - CRC-16/CCITT-FALSE: poly 0x1021, MSB-first, no reflection, no final XOR, computed over payload bytes only.
  - Byte-wide update is combinational in one cycle, so back-to-back strobes are supported.
- Latency: frame_valid asserts 2 cycles after the strobe of the last CRC byte.
- payload is stable between frame_valid pulses and is never modified by bad or aborted frames.
- busy = (state != HUNT).

Optional Feature:
- Macro: FRAME_TIMEOUT_EN.
- Defined:
  - An idle counter counts cycles without a strobe while state ∈ {PAYLOAD, CRC_HI, CRC_LO}; it clears on every strobe.
  - When it reaches TIMEOUT_CYCLES: return to HUNT, clear window, pulse timeout for 1 cycle, error_count++ (saturating).
  - A strobe on the same cycle as expiry wins: the byte is consumed and the counter clears.
- Not defined: no idle counter; timeout is tied 0; a stalled frame waits indefinitely.

Decomposition:
- Shared package uart_frame_pkg:
  - MAGIC default; CRC polynomial 16'h1021; CRC_INIT.
  - State encoding localparams HUNT=0, PAYLOAD=1, CRC_HI=2, CRC_LO=3, CHECK=4.
  - Reused by the matching uart_frame_encoder on the TX side.
- One sub-module: crc16_ccitt_byte. Purely combinational: crc_in[15:0], data[7:0] -> crc_out[15:0]. Shared with the encoder.

Test Plan:
- PAYLOAD_BYTES=9, send DA BB AD 00, "123456789" (31..39), 29 B1 -> frame_valid 2 cycles after last strobe; payload[7:0]=0x31, payload[71:64]=0x39; frame_count=1.
- Same frame with CRC bytes 29 B0 -> crc_error pulse; frame_valid stays 0; payload unchanged; error_count=1.
- Leading garbage 00 DA DA BB AD 00 followed by a valid frame -> exactly one frame_valid, correct payload.
- Valid frame sent with back-to-back strobes (one per cycle) -> same result as spaced strobes.
- Assert reset after 5 payload bytes, then send a full valid frame -> outputs zero during reset; the new frame decodes correctly.
- With FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=100: header + 3 bytes, then 100 idle cycles -> timeout pulse, busy=0; a following valid frame decodes.
